// File: rtl/inst_encoder.sv
// Descriptor-to-RV32I instruction packer. Accepts one decoded descriptor per
// cycle, encodes it, and writes the word to imem at an auto-incrementing
// byte address starting from a programmable base.
module inst_encoder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_e;
  typedef enum logic [1:0] {E_NONE = 2'b00, E_OP = 2'b01, E_IMM = 2'b10, E_OVF = 2'b11} err_e;
  typedef enum logic [3:0] {
    OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_ADD, OP_SUB,
    OP_XOR, OP_SRL, OP_OR, OP_AND, OP_JALR
  } op_e;

  state_e            state_q, state_d;
  err_e              code_q, code_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        op_illegal;
  logic        imm_bad;
  logic        fits_12;
  logic        fits_b;

  // Sign-extension checks: upper bits must all replicate the sign bit.
  assign fits_12 = (cmd_imm[31:11] == '0) || (cmd_imm[31:11] == '1);
  assign fits_b  = (cmd_imm[31:12] == '0) || (cmd_imm[31:12] == '1);

  // Pack the current descriptor and classify op/immediate legality.
  always_comb begin
    word       = '0;
    op_illegal = 1'b0;
    imm_bad    = 1'b0;
    case (cmd_op)
      OP_BEQ: begin
        word    = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b000,
                   cmd_imm[4:1], cmd_imm[11], 7'b1100011};
        imm_bad = !fits_b || cmd_imm[0];
      end
      OP_LW: begin
        word    = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
        imm_bad = !fits_12;
      end
      OP_SW: begin
        word    = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
        imm_bad = !fits_12;
      end
      OP_ADDI: begin
        word    = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b0010011};
        imm_bad = !fits_12;
      end
      OP_ADD:  word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, 7'b0110011};
      OP_SUB:  word = {7'b0100000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, 7'b0110011};
      OP_XOR:  word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b100, cmd_rd, 7'b0110011};
      OP_SRL:  word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b101, cmd_rd, 7'b0110011};
      OP_OR:   word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b110, cmd_rd, 7'b0110011};
      OP_AND:  word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b111, cmd_rd, 7'b0110011};
      OP_JALR: begin
        word    = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b1100111};
        imm_bad = !fits_12;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  // Next-state: start always wins; otherwise an accepted descriptor either
  // schedules a write for the following cycle or latches an error.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    cmd_ready = (state_q == S_RUN) && !start;

    if (start) begin
      state_d = S_RUN;
      ptr_d   = base_addr & ~ADDR_W'(3);
      cnt_d   = '0;
      err_d   = 1'b0;
      code_d  = E_NONE;
    end else if (cmd_valid && cmd_ready) begin
      if (op_illegal || imm_bad || (cnt_q == CNT_W'(DEPTH))) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        if (op_illegal)   code_d = E_OP;
        else if (imm_bad) code_d = E_IMM;
        else              code_d = E_OVF;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + ADDR_W'(4);
        cnt_d   = cnt_q + 1'b1;
        done_d  = cmd_last;
        if (cmd_last) state_d = S_IDLE;
      end
    end
  end

  // State and output registers; reset drops any scheduled write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= E_NONE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign wr_count   = cnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus randomized descriptor
// streams, all checked against an arithmetic encoding/behaviour model.
module tb_inst_encoder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              cmd_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [CNT_W-1:0]  wr_count;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .wr_count(wr_count), .done(done), .err(err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_run;
  bit          m_err;
  int          m_code;
  int          m_cnt;
  logic [31:0] m_ptr;
  bit          m_acc;
  bit          exp_we;
  bit          exp_done;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Encoding built from field weights rather than bit concatenation.
  function automatic logic [31:0] ref_enc(input int unsigned op, input int unsigned rd,
                                          input int unsigned rs1, input int unsigned rs2,
                                          input int unsigned u);
    int unsigned f3, f7, opc;
    case (op)
      4, 5, 6, 7, 8, 9: begin
        f3 = (op == 6) ? 4 : (op == 7) ? 5 : (op == 8) ? 6 : (op == 9) ? 7 : 0;
        f7 = (op == 5) ? 32 : 0;
        return f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
      end
      1, 3, 10: begin
        opc = (op == 1) ? 3 : (op == 3) ? 19 : 103;
        f3  = (op == 1) ? 2 : 0;
        return (u % 4096) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
      end
      2: return ((u / 32) % 128) * 33554432 + rs2 * 1048576 + rs1 * 32768 + 2 * 4096
                + (u % 32) * 128 + 35;
      0: return ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432
                + rs2 * 1048576 + rs1 * 32768 + ((u / 2) % 16) * 256
                + ((u / 2048) % 2) * 128 + 99;
      default: return 32'h0;
    endcase
  endfunction

  // 0 ok, 1 illegal op, 2 immediate out of range
  function automatic int ref_class(input int op, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (op > 10) return 1;
    if (op == 1 || op == 2 || op == 3 || op == 10) return (s < -2048 || s > 2047) ? 2 : 0;
    if (op == 0) return (s < -4096 || s > 4094 || (s % 2) != 0) ? 2 : 0;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_code = 0; m_cnt = 0; m_ptr = '0;
  endtask

  // One clock: predict from the inputs driven this cycle, then compare.
  task automatic cycle();
    int code;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(m_run && !start));
    exp_we = 0; exp_done = 0; m_acc = 0;
    if (start) begin
      m_run = 1; m_err = 0; m_code = 0; m_cnt = 0;
      m_ptr = base_addr & 32'hFFFF_FFFC;
    end else if (m_run && cmd_valid) begin
      m_acc = 1;
      code = ref_class(int'(cmd_op), cmd_imm);
      if (code == 0 && m_cnt == DEPTH) code = 3;
      if (code != 0) begin
        m_run = 0; m_err = 1; m_code = code;
      end else begin
        exp_we   = 1;
        exp_addr = m_ptr;
        exp_data = ref_enc(32'(cmd_op), 32'(cmd_rd), 32'(cmd_rs1), 32'(cmd_rs2), cmd_imm);
        m_ptr    = m_ptr + 32'd4;
        m_cnt++;
        exp_done = cmd_last;
        if (cmd_last) m_run = 0;
      end
    end
    @(posedge clk);
    #1;
    check("imem_we", 32'(imem_we), 32'(exp_we));
    check("done", 32'(done), 32'(exp_done));
    if (exp_we) begin
      check("imem_addr", imem_addr, exp_addr);
      check("imem_wdata", imem_wdata, exp_data);
    end
    check("wr_count", 32'(wr_count), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1; base_addr = base; cmd_valid = 0;
    cycle();
    start = 0;
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit last);
    bit got;
    cmd_op = 4'(op); cmd_rd = 5'(rd); cmd_rs1 = 5'(rs1); cmd_rs2 = 5'(rs2);
    cmd_imm = imm; cmd_last = last; cmd_valid = 1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = m_acc;
    end
    check("issue_accept", 32'(got), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_count"}, 32'(wr_count), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  bit need_new;

  initial begin
    rst_n = 0; start = 0; base_addr = '0; cmd_valid = 0; cmd_op = '0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; cmd_last = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    idle(2);

    // Single ADDI program
    do_start(32'h100);
    issue(3, 1, 0, 0, 32'd5, 1);
    check("addi_addr", imem_addr, 32'h100);
    check("addi_data", imem_wdata, 32'h0050_0093);
    check("addi_done", 32'(done), 32'd1);
    check("addi_count", 32'(wr_count), 32'd1);
    idle(1);

    // Back-to-back stream; start in IDLE with valid high is not an accept
    cmd_valid = 1; cmd_op = 4'd4; cmd_rd = 5'd3; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2;
    cmd_imm = '0; cmd_last = 0; start = 1; base_addr = 32'h0;
    cycle();
    start = 0;
    issue(4, 3, 1, 2, 32'd0, 0);
    check("add_data", imem_wdata, 32'h0020_81B3);
    issue(5, 3, 1, 2, 32'd0, 0);
    check("sub_data", imem_wdata, 32'h4020_81B3);
    issue(1, 5, 2, 0, 32'd8, 0);
    check("lw_data", imem_wdata, 32'h0081_2283);
    issue(2, 0, 2, 5, 32'd12, 0);
    check("sw_data", imem_wdata, 32'h0051_2623);
    issue(10, 1, 5, 0, 32'd0, 1);
    check("jalr_addr", imem_addr, 32'h10);
    check("jalr_data", imem_wdata, 32'h0002_80E7);
    idle(1);

    // BEQ encodings and misaligned offset
    do_start(32'h40);
    issue(0, 0, 1, 2, -32'sd8, 0);
    check("beq_data", imem_wdata, 32'hFE20_8CE3);
    issue(0, 0, 1, 2, -32'sd7, 0);
    check("beq_odd_code", 32'(err_code), 32'd2);
    idle(2);
    do_start(32'h80);
    check("restart_err", 32'(err), 32'd0);
    issue(6, 7, 8, 9, 32'd0, 1);
    idle(1);

    // Illegal op, then I-type immediate just past range
    do_start(32'h0);
    issue(12, 1, 1, 1, 32'd0, 0);
    check("illegal_code", 32'(err_code), 32'd1);
    idle(2);
    do_start(32'h0);
    issue(3, 1, 1, 0, 32'd2048, 0);
    check("imm2048_code", 32'(err_code), 32'd2);
    idle(1);

    // Overflow at DEPTH
    do_start(32'h200);
    for (int k = 0; k < DEPTH; k++) issue(8, k, k + 1, k + 2, 32'd0, 0);
    issue(9, 1, 2, 3, 32'd0, 0);
    check("ovf_code", 32'(err_code), 32'd3);
    idle(1);

    // Address wrap
    do_start(32'hFFFF_FFF8);
    issue(3, 1, 1, 0, 32'd1, 0);
    check("wrap0", imem_addr, 32'hFFFF_FFF8);
    issue(3, 1, 1, 0, 32'd2, 0);
    check("wrap1", imem_addr, 32'hFFFF_FFFC);
    issue(3, 1, 1, 0, 32'd3, 1);
    check("wrap2", imem_addr, 32'h0);
    idle(1);

    // Restart while a write is in flight
    do_start(32'h300);
    issue(4, 1, 2, 3, 32'd0, 0);
    start = 1; base_addr = 32'h400; cmd_valid = 0;
    cycle();
    start = 0;
    check("restart_count", 32'(wr_count), 32'd0);
    issue(4, 1, 2, 3, 32'd0, 1);
    check("restart_addr", imem_addr, 32'h400);
    idle(1);

    // Reset mid-stream
    do_start(32'h500);
    issue(7, 1, 2, 3, 32'd0, 0);
    #2 rst_n = 0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cmd_valid = 1;
    for (int k = 0; k < 3; k++) cycle();
    cmd_valid = 0;

    // Randomized streams
    need_new = 1;
    for (int i = 0; i < 800; i++) begin
      start = (!m_run && $urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0);
      if (start) base_addr = $urandom;
      if (need_new) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(11, 15))
                                              : 4'($urandom_range(0, 10));
        cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
          0, 1: cmd_imm = 32'(int'($urandom_range(0, 40)) - 20);
          2:    cmd_imm = $urandom;
          3:    cmd_imm = $urandom_range(0, 1) ? 32'(2045 + int'($urandom_range(0, 5)))
                                               : 32'(-4099 + int'($urandom_range(0, 6)));
          default: cmd_imm = $urandom_range(0, 1) ? 32'(4092 + int'($urandom_range(0, 5)))
                                                  : 32'(-2051 + int'($urandom_range(0, 5)));
        endcase
        cmd_last = ($urandom_range(0, 5) == 0);
      end
      cycle();
      need_new = m_acc || !cmd_valid;
    end
    start = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streams decoded instruction descriptors (operation, register indices, immediate) and packs each into a 32-bit RV32I instruction word.
- Writes each word sequentially into instruction memory from a programmable base address.
- Produces exactly the encodings the core's decoder consumes (BEQ, LW, SW, ADDI, ADD, SUB, XOR, SRL, OR, AND, JALR).
- Sits between the test/boot loader and imem; it is the write-side counterpart of instruction decode.

Parameters:
- ADDR_W, 32, imem byte-address width.
- DEPTH, 256, maximum words written per program (start to done).
- CNT_W, 9, width of the word counter; must hold DEPTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a program at base_addr.
- base_addr  in  ADDR_W  first write address, word aligned (bits [1:0] ignored, treated as 0).
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  encoder accepts descriptor this cycle.
- cmd_op  in  4  0 BEQ, 1 LW, 2 SW, 3 ADDI, 4 ADD, 5 SUB, 6 XOR, 7 SRL, 8 OR, 9 AND, 10 JALR, 11-15 illegal.
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register indices.
- cmd_imm  in  32  signed immediate (byte offset for BEQ).
- cmd_last  in  1  final descriptor of the program.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write byte address.
- imem_wdata  out  32  encoded instruction.
- wr_count  out  CNT_W  words written since the last start.
- done  out  1  one-cycle pulse.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 illegal op, 10 immediate out of range, 11 overflow.

Behaviour:
- Reset (async, rst_n=0): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, wr_count=0, done=0, err=0, err_code=00, cmd_ready=0. Any in-flight write is dropped.
- States: IDLE, RUN, ERR.
  - IDLE: cmd_ready=0. start -> RUN; the write address pointer loads base_addr, wr_count clears.
  - RUN: cmd_ready = 1 when start=0, else 0. A descriptor is accepted on cmd_valid & cmd_ready.
  - ERR: cmd_ready=0; err and err_code hold. start -> RUN, clearing err, err_code and wr_count and reloading the pointer.
- Handshake: cmd_valid with cmd_ready=0 has no effect. The source holds its fields until accepted.
- Latency: a descriptor accepted at edge N drives imem_we=1 with imem_addr/imem_wdata for exactly the cycle after edge N. Back-to-back accepts give a write every cycle. imem_we=0 otherwise.
- Addressing: each write uses the current pointer; the pointer then increments by 4, wrapping mod 2^ADDR_W. wr_count increments with each write.
- Encoding (unused fields ignored):
  - R-type (ADD/SUB/XOR/SRL/OR/AND): opcode 0110011; funct3 000/000/100/101/110/111; funct7 0100000 for SUB, 0000000 otherwise. Immediate ignored.
  - I-type: LW is opcode 0000011, funct3 010. ADDI is 0010011, funct3 000. JALR is 1100111, funct3 000. Fields are imm[11:0], rs1, rd.
  - S-type: SW is opcode 0100011, funct3 010. Fields are imm[11:5], rs2, rs1, imm[4:0]. rd ignored.
  - B-type: BEQ is opcode 1100011, funct3 000. Fields are imm[12], imm[10:5], rs2, rs1, imm[4:1], imm[11]. rd ignored.
- Immediate checks: I/S types require -2048 to 2047. BEQ requires -4096 to 4094 with bit 0 = 0.
- Errors, evaluated at accept:
  - An illegal op sets code 01; an immediate failure sets 10. Either one: no write issued, go to ERR, err=1.
  - Overflow: accepting when wr_count plus any pending write equals DEPTH sets code 11 and goes to ERR.
  - Priority is 01 > 10 > 11.
- Completion: an accept with cmd_last=1 and no error returns the FSM to IDLE. done pulses in the same cycle that descriptor's imem_we is high.
- Simultaneous events:
  - start in RUN restarts the program. A write already registered still completes at its old address.
  - start while imem_we is high from the previous accept: the write completes and wr_count then reads 0.
  - start in IDLE together with cmd_valid: not accepted.
- Reset mid-program: immediate abort, no further writes.

Test Plan:
- Reset, start with base 0x100, ADDI rd=1 rs1=0 imm=5 last=1 -> one cycle later imem_we=1, addr 0x100, data 0x00500093; done=1 same cycle; wr_count=1; back in IDLE.
- Back-to-back stream from base 0 with cmd_valid held high: ADD(3,1,2), SUB(3,1,2), LW(rd5,rs1 2,imm 8), SW(rs2 5,rs1 2,imm 12), JALR(rd1,rs1 5,imm 0, last) -> writes on consecutive cycles at 0,4,8,C,10 with data 002081B3, 402081B3, 00812283, 00512623, 000280E7.
- BEQ rs1=1 rs2=2 imm=-8 -> data FE208CE3. BEQ imm=-7 -> err=1, code 10, no write. Then start -> err clears and a following write succeeds.
- cmd_op=12 -> err code 01, cmd_ready=0, no imem_we. ADDI imm=2048 -> code 10.
- With DEPTH=4, send 5 descriptors without last -> 4 writes, the 5th accept gives code 11 and no write. Base 0xFFFFFFF8 with ADDR_W=32 and 3 writes -> addresses FFFFFFF8, FFFFFFFC, 00000000.
- rst_n low during a stream -> all outputs zero asynchronously; no writes after release until start.
